// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared constants, step encoding and width-generic Gray/binary
//               conversion helpers for the parametrised Gray counter.
// Revision    : 1.0  initial release
// ============================================================================
package gray_pkg;

    // Default counter width when the parameter is not overridden.
    localparam int DEFAULT_WIDTH = 3;

    // Widest vector the conversion helpers accept; narrower callers
    // zero-extend on the way in and truncate on the way out.
    localparam int GRAY_MAX_W = 32;

    // Per-edge action selected by the priority decoder (load > en > hold).
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } step_op_e;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    // Zero upper bits keep the result valid for any narrower width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR from the MSB downwards.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_bin
// Description : Combinational WIDTH-bit Gray-to-binary converter; binary bit i
//               is the XOR reduction of Gray bits WIDTH-1 down to i.
// Revision    : 1.0  initial release
// ============================================================================
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each output bit reduces its own slice, so there is no ripple chain
    // feeding back through the output vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule
`default_nettype wire

// File: rtl/gray_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_param
// Description : Parametrised up/down Gray-code counter with count enable,
//               Gray-coded parallel load, registered binary mirror, zero flag
//               and a registered wrap pulse.
//               Build option GRAY_CNT_SATURATE_EN: when defined the counter
//               saturates at both ends instead of wrapping and wrap stays 0.
// Revision    : 1.0  initial release
// ============================================================================
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RESET_BIN = 0
) (
    input  logic             clock,
    input  logic             reset,      // asynchronous, active-low
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             at_zero,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_RESET_BIN  = WIDTH'(RESET_BIN);
    localparam logic [WIDTH-1:0] c_RESET_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(c_RESET_BIN)));
    localparam logic [WIDTH-1:0] c_MAX_BIN    = '1;
    localparam logic [WIDTH-1:0] c_ZERO       = '0;
    localparam logic [WIDTH-1:0] c_ONE        = WIDTH'(1);

    // Binary state is authoritative; the Gray register is a same-edge copy
    // so the two outputs can never be observed disagreeing.
    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] w_load_bin;
    step_op_e         w_op;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray_i (load_gray),
        .bin_o  (w_load_bin)
    );

    // Priority decode of the per-edge action: load beats enable beats hold.
    always_comb begin
        w_op = OP_HOLD;
        if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            w_op = up_dn ? OP_UP : OP_DOWN;
        end
    end

    // Next binary value and wrap pulse; Gray follows from the next binary.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        case (w_op)
            OP_LOAD: begin
                bin_d = w_load_bin;
            end
            OP_UP: begin
`ifdef GRAY_CNT_SATURATE_EN
                if (bin_q != c_MAX_BIN) begin
                    bin_d = bin_q + c_ONE;
                end
`else
                bin_d  = bin_q + c_ONE;
                wrap_d = (bin_q == c_MAX_BIN);
`endif
            end
            OP_DOWN: begin
`ifdef GRAY_CNT_SATURATE_EN
                if (bin_q != c_ZERO) begin
                    bin_d = bin_q - c_ONE;
                end
`else
                bin_d  = bin_q - c_ONE;
                wrap_d = (bin_q == c_ZERO);
`endif
            end
            default: begin
                bin_d = bin_q;
            end
        endcase
        gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bin_q  <= c_RESET_BIN;
            gray_q <= c_RESET_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign gray    = gray_q;
    assign bin     = bin_q;
    assign wrap    = wrap_q;
    assign at_zero = (gray_q == c_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter_param
// Description : Directed self-checking bench for gray_counter_param; a 3-bit
//               instance for the sequence/priority/reset cases and a 5-bit
//               instance for a full cycle with interleaved hold cycles.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gray_counter_param;

    logic       clk;
    logic       rst_n;

    logic       en3, up3, ld3;
    logic [2:0] ldg3;
    logic [2:0] gray3, bin3;
    logic       z3, wr3;

    logic       en5, up5, ld5;
    logic [4:0] ldg5;
    logic [4:0] gray5, bin5;
    logic       z5, wr5;

    int n_checks = 0;
    int n_errors = 0;

    gray_counter_param #(.WIDTH(3), .RESET_BIN(0)) u_dut3 (
        .clock (clk), .reset (rst_n), .en (en3), .up_dn (up3), .load (ld3),
        .load_gray (ldg3), .gray (gray3), .bin (bin3), .at_zero (z3), .wrap (wr3)
    );

    gray_counter_param #(.WIDTH(5), .RESET_BIN(0)) u_dut5 (
        .clock (clk), .reset (rst_n), .en (en5), .up_dn (up5), .load (ld5),
        .load_gray (ldg5), .gray (gray5), .bin (bin5), .at_zero (z5), .wrap (wr5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected 3-bit up run from reset: gray, bin, wrap, at_zero per edge.
`ifdef GRAY_CNT_SATURATE_EN
    int exp_g1[9]  = '{1, 3, 2, 6, 7, 5, 4, 4, 4};
    int exp_b1[9]  = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    int exp_w1[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_z1[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    int exp_g1[9]  = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    int exp_b1[9]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int exp_w1[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp_z1[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif

    initial begin
        int   mb;
        int   mw;
        int   wraps;
        logic [4:0] prev_g;

        rst_n = 1'b0;
        en3 = 1'b1; up3 = 1'b1; ld3 = 1'b0; ldg3 = 3'd0;
        en5 = 1'b0; up5 = 1'b1; ld5 = 1'b0; ldg5 = 5'd0;

        // 1: reset state, then up count across the top of the range
        #3;
        chk("rst_gray", gray3, 3'b000);
        chk("rst_bin",  bin3,  3'd0);
        chk("rst_zero", z3,    1'b1);
        chk("rst_wrap", wr3,   1'b0);
        tick();
        chk("rst_hold_gray", gray3, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("up%0d_gray", i), gray3, exp_g1[i]);
            chk($sformatf("up%0d_bin",  i), bin3,  exp_b1[i]);
            chk($sformatf("up%0d_wrap", i), wr3,   exp_w1[i]);
            chk($sformatf("up%0d_zero", i), z3,    exp_z1[i]);
        end

        // 2: load zero, then count down across the bottom of the range
        ld3 = 1'b1; ldg3 = 3'b000; en3 = 1'b0;
        tick();
        chk("ld0_gray", gray3, 3'b000);
        chk("ld0_zero", z3,    1'b1);
        ld3 = 1'b0; en3 = 1'b1; up3 = 1'b0;
        tick();
`ifdef GRAY_CNT_SATURATE_EN
        chk("dn0_gray", gray3, 3'b000);
        chk("dn0_bin",  bin3,  3'd0);
        chk("dn0_wrap", wr3,   1'b0);
        tick();
        chk("dn1_gray", gray3, 3'b000);
        chk("dn1_wrap", wr3,   1'b0);
`else
        chk("dn0_gray", gray3, 3'b100);
        chk("dn0_bin",  bin3,  3'd7);
        chk("dn0_wrap", wr3,   1'b1);
        tick();
        chk("dn1_gray", gray3, 3'b101);
        chk("dn1_bin",  bin3,  3'd6);
        chk("dn1_wrap", wr3,   1'b0);
`endif

        // 3: load has priority over an active up-count
        ld3 = 1'b1; ldg3 = 3'b110; en3 = 1'b1; up3 = 1'b1;
        tick();
        chk("ld_gray", gray3, 3'b110);
        chk("ld_bin",  bin3,  3'd4);
        chk("ld_wrap", wr3,   1'b0);
        ld3 = 1'b0;
        tick();
        chk("ld_next_gray", gray3, 3'b111);
        chk("ld_next_bin",  bin3,  3'd5);

        // hold with en low
        en3 = 1'b0;
        tick();
        chk("hold_gray", gray3, 3'b111);
        chk("hold_wrap", wr3,   1'b0);

        // 4: asynchronous reset between edges, held against en/load
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gray", gray3, 3'b000);
        chk("arst_bin",  bin3,  3'd0);
        chk("arst_zero", z3,    1'b1);
        en3 = 1'b1; ld3 = 1'b1; ldg3 = 3'b101;
        tick();
        tick();
        chk("arst_held_gray", gray3, 3'b000);
        chk("arst_held_wrap", wr3,   1'b0);
        ld3 = 1'b0; en3 = 1'b0;
        rst_n = 1'b1;
        tick();

`ifdef GRAY_CNT_SATURATE_EN
        // 6: saturation at the top of the range
        ld3 = 1'b1; ldg3 = 3'b100;
        tick();
        ld3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat%0d_gray", i), gray3, 3'b100);
            chk($sformatf("sat%0d_wrap", i), wr3,   1'b0);
        end
        en3 = 1'b0;
`endif

        // 5: 5-bit full up cycle with every fourth cycle held
        chk("w5_rst_gray", gray5, 5'd0);
        chk("w5_rst_zero", z5,    1'b1);
        mb = 0; wraps = 0; up5 = 1'b1;
        for (int i = 0; i < 43; i++) begin
            en5 = ((i % 4) != 3);
            prev_g = gray5;
            mw = 0;
            if (en5) begin
`ifdef GRAY_CNT_SATURATE_EN
                if (mb != 31) mb = mb + 1;
`else
                if (mb == 31) begin
                    mb = 0;
                    mw = 1;
                end else begin
                    mb = mb + 1;
                end
`endif
            end
            tick();
            chk($sformatf("w5_%0d_bin",  i), bin5,  mb);
            chk($sformatf("w5_%0d_gray", i), gray5, mb ^ (mb >> 1));
            chk($sformatf("w5_%0d_wrap", i), wr5,   mw);
            chk($sformatf("w5_%0d_conv", i), bin5,  {gray5[4], ^gray5[4:3], ^gray5[4:2], ^gray5[4:1], ^gray5[4:0]});
            if (gray5 !== prev_g)
                chk($sformatf("w5_%0d_1bit", i), $countones(gray5 ^ prev_g), 1);
            if (wr5 === 1'b1) wraps++;
        end
`ifdef GRAY_CNT_SATURATE_EN
        chk("w5_wraps", wraps, 0);
`else
        chk("w5_wraps", wraps, 1);
`endif
        en5 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
